// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One operand bit per cycle in RUN; sign correction and HI/LO write in FINISH.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_FINISH = 2'b10
   } state_t;

   state_t               state_r;
   logic [CW-1:0]        cnt_r;
   logic [2*WIDTH:0]     acc_r;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]     opb_r;
   logic [WIDTH-1:0]     a_orig_r;
   logic                 is_div_r;
   logic                 neg_res_r;
   logic                 neg_rem_r;
   logic                 dbz_r;
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;

   logic                 signed_op_s;
   logic [WIDTH-1:0]     mag_a_s;
   logic [WIDTH-1:0]     mag_b_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH:0]     mul_next_s;
   logic [2*WIDTH:0]     div_shift_s;
   logic                 div_ge_s;
   logic [2*WIDTH:0]     div_next_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quot_s;
   logic [WIDTH-1:0]     rem_s;
   logic [WIDTH-1:0]     res_hi_s;
   logic [WIDTH-1:0]     res_lo_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      logic [WIDTH-1:0] r;
      if (sgn && v[WIDTH-1]) begin
         r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Operand magnitudes for the op being issued this cycle.
   always_comb begin
      signed_op_s = ~op[0];
      mag_a_s     = magnitude(a, signed_op_s);
      mag_b_s     = magnitude(b, signed_op_s);
   end

   // One shift-add and one restoring shift-subtract step from the current accumulator.
   always_comb begin
      mul_sum_s   = acc_r[2*WIDTH:WIDTH] + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
      mul_next_s  = {1'b0, mul_sum_s, acc_r[WIDTH-1:1]};
      div_shift_s = {acc_r[2*WIDTH-1:0], 1'b0};
      div_ge_s    = (div_shift_s[2*WIDTH:WIDTH] >= {1'b0, opb_r});
      if (div_ge_s) begin
         div_next_s = {div_shift_s[2*WIDTH:WIDTH] - {1'b0, opb_r},
                       div_shift_s[WIDTH-1:1], 1'b1};
      end else begin
         div_next_s = div_shift_s;
      end
   end

   // Sign-corrected result; divide by zero bypasses correction.
   always_comb begin
      prod_s = neg_res_r ? ((~acc_r[2*WIDTH-1:0]) + {{(2*WIDTH-1){1'b0}}, 1'b1})
                         : acc_r[2*WIDTH-1:0];
      quot_s = neg_res_r ? ((~acc_r[WIDTH-1:0]) + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_r[WIDTH-1:0];
      rem_s  = neg_rem_r ? ((~acc_r[2*WIDTH-1:WIDTH]) + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_r[2*WIDTH-1:WIDTH];
      if (!is_div_r) begin
         res_hi_s = prod_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end else if (dbz_r) begin
         res_hi_s = a_orig_r;
         res_lo_s = {WIDTH{1'b1}};
      end else begin
         res_hi_s = rem_s;
         res_lo_s = quot_s;
      end
   end

   // Control FSM, iteration datapath and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         cnt_r     <= {CW{1'b0}};
         acc_r     <= {(2*WIDTH+1){1'b0}};
         opb_r     <= {WIDTH{1'b0}};
         a_orig_r  <= {WIDTH{1'b0}};
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         dbz_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start && !cancel) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        is_div_r  <= op[1];
                        neg_res_r <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_r <= signed_op_s & a[WIDTH-1];
                        dbz_r     <= (b == {WIDTH{1'b0}});
                        a_orig_r  <= a;
                        opb_r     <= mag_b_s;
                        acc_r     <= {{(WIDTH+1){1'b0}}, mag_a_s};
                        cnt_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= S_RUN;
                     end
                     OP_MTHI: hi_r <= a;
                     OP_MTLO: lo_r <= a;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (cancel) begin
                  busy_r  <= 1'b0;
                  cnt_r   <= {CW{1'b0}};
                  state_r <= S_IDLE;
               end else begin
                  acc_r <= is_div_r ? div_next_s : mul_next_s;
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  if (cnt_r == LAST_STEP) begin
                     state_r <= S_FINISH;
                  end else begin
                     state_r <= S_RUN;
                  end
               end
            end
            S_FINISH: begin
               busy_r  <= 1'b0;
               cnt_r   <= {CW{1'b0}};
               state_r <= S_IDLE;
               if (!cancel) begin
                  hi_r   <= res_hi_s;
                  lo_r   <= res_lo_s;
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [63:0]   exp_q[$];
   logic [W-1:0]  cur_hi = 32'h0;
   logic [W-1:0]  cur_lo = 32'h0;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: {hi, lo} from 64-bit integer arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sq, sr;
      longint unsigned ux, uy, uq, ur;
      logic [63:0]     r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      r  = 64'h0;
      case (o)
         3'd0: r = sx * sy;
         3'd1: r = ux * uy;
         3'd2: begin
            if (y == 32'h0) r = {x, 32'hFFFFFFFF};
            else begin
               sq = sx / sy;
               sr = sx % sy;
               r  = {sr[31:0], sq[31:0]};
            end
         end
         3'd3: begin
            if (y == 32'h0) r = {x, 32'hFFFFFFFF};
            else begin
               uq = ux / uy;
               ur = ux % uy;
               r  = {ur[31:0], uq[31:0]};
            end
         end
         default: r = 64'h0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_val();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0: v = 32'h0;
         1: v = 32'hFFFFFFFF;
         2: v = 32'h80000000;
         3: v = 32'h1;
         4: v = $urandom_range(0, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: every done pulse pops and compares the next expected result.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
         end else begin
            e = exp_q.pop_front();
            check("result_hilo", {hi, lo}, e);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit expect_res);
      int t;
      t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: got busy=1, required busy=0 within 200 cycles");
      end
      start = 1'b1; op = o; a = x; b = y;
      if (expect_res && o <= 3'd3) exp_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0;
      if (o == 3'd4) cur_hi = x;
      else if (o == 3'd5) cur_lo = x;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got done=0, required done within 100 cycles", name);
      end
   endtask

   initial begin
      int cnt;
      logic [2:0] ro;
      rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0; cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_state", {28'h0, busy, done, 2'b00, hi}, {28'h0, 1'b0, 1'b0, 2'b00, 32'h0});
      check("reset_lo", {32'h0, lo}, 64'h0);

      // MULTU max x max: latency and busy length
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) cnt++;
         else break;
      end
      check("multu_busy_cycles", 64'(cnt), 64'd33);
      check("multu_done_after_busy", {63'h0, done}, 64'h1);

      // MULT -3*7 then DIV -7/2 issued in the done cycle
      issue(3'd0, 32'hFFFFFFFD, 32'd7, 1'b1);
      wait_done("mult");
      check("mult_m3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
      @(negedge clk);
      check("div_accepted_in_done_cycle", {63'h0, busy}, 64'h1);
      wait_done("div");
      check("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

      // Divide by zero and signed overflow
      issue(3'd3, 32'd100, 32'd0, 1'b1);
      wait_done("divu0");
      check("divu_by_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_done("divovf");
      check("div_overflow", {hi, lo}, 64'h00000000_80000000);

      // Cancel at cycle 10 together with start+MTHI
      issue(3'd1, 32'd5, 32'd6, 1'b0);
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1; start = 1'b1; op = 3'd4; a = 32'hCAFEF00D;
      @(posedge clk); #1;
      cancel = 1'b0; start = 1'b0;
      @(negedge clk);
      check("cancel_busy_done", {62'h0, busy, done}, 64'h0);
      check("cancel_hilo_kept", {hi, lo}, {cur_hi, cur_lo});
      repeat (40) @(negedge clk);
      check("cancel_hilo_later", {hi, lo}, {cur_hi, cur_lo});

      // MTLO in idle, MTHI while busy
      issue(3'd5, 32'h12345678, 32'h0, 1'b0);
      @(negedge clk);
      check("mtlo_value", {32'h0, lo}, {32'h0, 32'h12345678});
      check("mtlo_busy_done", {62'h0, busy, done}, 64'h0);
      issue(3'd0, 32'h00001234, 32'hFFFF0000, 1'b1);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("mthi_while_busy", {32'h0, hi}, {32'h0, cur_hi});
      wait_done("mult_after_mthi");

      // Reset in the middle of a DIVU, then a fresh op
      issue(3'd3, 32'd1000, 32'd7, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      cur_hi = 32'h0; cur_lo = 32'h0;
      @(negedge clk);
      check("midop_reset", {hi, lo}, 64'h0);
      check("midop_reset_flags", {62'h0, busy, done}, 64'h0);
      issue(3'd3, 32'd1000, 32'd7, 1'b1);
      wait_done("after_reset");
      check("after_reset_divu", {hi, lo}, 64'h00000006_0000008E);

      // Random mix, back-to-back where possible
      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom_range(0, 7));
         issue(ro, rand_val(), rand_val(), 1'b1);
         if (ro >= 3'd4) begin
            @(negedge clk);
            check("rand_mt_or_nop", {hi, lo}, {cur_hi, cur_lo});
            check("rand_mt_flags", {62'h0, busy, done}, 64'h0);
         end
      end

      cnt = 0;
      while ((exp_q.size() != 0 || busy) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
